// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a write-side byte FIFO.
//   Frame = start bit, 5..8 data bits (LSB first), optional odd/even parity,
//   1 or 2 stop bits. Each bit lasts baud_div+1 clocks. Frame options and the
//   divisor are captured when a byte is popped, so they can change freely
//   while a frame is in flight.
// Ports:
//   clock, rst             - clock, async active-low reset
//   wr_valid/data_in       - byte write; accepted when wr_ready (= !fifo_full)
//   tx_enable              - allows new frames to start
//   baud_div               - bit period minus one, in clocks
//   data_len/parity_type   - 5+data_len data bits; 01=odd, 10=even, else none
//   stop_bits              - 0 = one stop bit, 1 = two
//   data_tx                - serial line, idles high
//   active_flag/done_flag  - frame in progress / last stop cycle pulse
//   fifo_empty/full/count  - FIFO occupancy
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic                        wr_valid,
  input  logic [7:0]                  data_in,
  output logic                        wr_ready,
  input  logic                        tx_enable,
  input  logic [DIV_WIDTH-1:0]        baud_div,
  input  logic [1:0]                  data_len,
  input  logic [1:0]                  parity_type,
  input  logic                        stop_bits,
  output logic                        data_tx,
  output logic                        active_flag,
  output logic                        done_flag,
  output logic                        fifo_empty,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  // Frame engine
  state_t               state;
  logic [DIV_WIDTH-1:0] div_l, div_cnt;
  logic [1:0]           len_l;
  logic                 par_en_l, par_bit, stop_l, stop_idx;
  logic [2:0]           bit_idx;
  logic [7:0]           shreg;

  logic       bit_end, last_data, stop_end, load, last_next, head_par;
  logic [7:0] head, head_masked;

  assign fifo_count = count;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign wr_ready   = !fifo_full;
  assign push       = wr_valid && !fifo_full;
  assign pop        = load;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Parity only covers the bits that will actually be sent.
  always_comb begin
    head_masked = head;
    case (data_len)
      2'b00:   head_masked[7:5] = 3'b000;
      2'b01:   head_masked[7:6] = 2'b00;
      2'b10:   head_masked[7]   = 1'b0;
      default: ;
    endcase
  end
  assign head_par = (^head_masked) ^ (parity_type == 2'b01);

  assign bit_end   = (div_cnt == div_l);
  assign last_data = (bit_idx == 3'd4 + {1'b0, len_l});
  assign stop_end  = (state == STOP) && bit_end && (stop_idx == stop_l);
  assign load      = tx_enable && !fifo_empty && ((state == IDLE) || stop_end);

  // done_flag is registered, so it is raised on the edge that enters the
  // final stop cycle. With a divisor above zero that is the second-to-last
  // cycle of the last stop bit; with a zero divisor every cycle is a bit
  // boundary, so the preceding bit decides.
  assign last_next =
      ((state == STOP) && (stop_idx == stop_l) && !bit_end && (div_cnt + 1'b1 == div_l)) ||
      ((div_l == '0) &&
       (((state == STOP) && !stop_idx && stop_l) ||
        (!stop_l && (((state == DATA) && last_data && !par_en_l) || (state == PARITY)))));

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      data_tx     <= 1'b1;
      active_flag <= 1'b0;
      done_flag   <= 1'b0;
      div_l       <= '0;
      div_cnt     <= '0;
      len_l       <= '0;
      par_en_l    <= 1'b0;
      par_bit     <= 1'b0;
      stop_l      <= 1'b0;
      stop_idx    <= 1'b0;
      bit_idx     <= '0;
      shreg       <= '0;
    end else begin
      done_flag <= last_next;
      if (load) begin
        // Pop from IDLE or straight out of the last stop cycle (no gap).
        shreg       <= head;
        div_l       <= baud_div;
        len_l       <= data_len;
        par_en_l    <= ^parity_type;
        par_bit     <= head_par;
        stop_l      <= stop_bits;
        div_cnt     <= '0;
        state       <= START;
        data_tx     <= 1'b0;
        active_flag <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            data_tx     <= 1'b1;
            active_flag <= 1'b0;
          end
          START: begin
            if (bit_end) begin
              div_cnt <= '0;
              bit_idx <= '0;
              state   <= DATA;
              data_tx <= shreg[0];
            end else div_cnt <= div_cnt + 1'b1;
          end
          DATA: begin
            if (bit_end) begin
              div_cnt <= '0;
              if (last_data) begin
                if (par_en_l) begin
                  state   <= PARITY;
                  data_tx <= par_bit;
                end else begin
                  state    <= STOP;
                  data_tx  <= 1'b1;
                  stop_idx <= 1'b0;
                end
              end else begin
                bit_idx <= bit_idx + 1'b1;
                shreg   <= shreg >> 1;
                data_tx <= shreg[1];
              end
            end else div_cnt <= div_cnt + 1'b1;
          end
          PARITY: begin
            if (bit_end) begin
              div_cnt  <= '0;
              state    <= STOP;
              data_tx  <= 1'b1;
              stop_idx <= 1'b0;
            end else div_cnt <= div_cnt + 1'b1;
          end
          STOP: begin
            if (bit_end) begin
              div_cnt <= '0;
              if (stop_idx == stop_l) begin
                state       <= IDLE;
                data_tx     <= 1'b1;
                active_flag <= 1'b0;
              end else stop_idx <= 1'b1;
            end else div_cnt <= div_cnt + 1'b1;
          end
          default: begin
            state       <= IDLE;
            data_tx     <= 1'b1;
            active_flag <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo.
module tb_uart_tx_fifo;
  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        wr_ready;
  logic        tx_enable = 1'b0;
  logic [15:0] baud_div = 16'd0;
  logic [1:0]  data_len = 2'b11;
  logic [1:0]  parity_type = 2'b00;
  logic        stop_bits = 1'b0;
  logic        data_tx, active_flag, done_flag, fifo_empty, fifo_full;
  logic [4:0]  fifo_count;

  int n_chk = 0;
  int n_fail = 0;

  logic cap_tx   [0:255];
  logic cap_done [0:255];

  uart_tx_fifo #(.FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
    .clock(clock), .rst(rst), .wr_valid(wr_valid), .data_in(data_in),
    .wr_ready(wr_ready), .tx_enable(tx_enable), .baud_div(baud_div),
    .data_len(data_len), .parity_type(parity_type), .stop_bits(stop_bits),
    .data_tx(data_tx), .active_flag(active_flag), .done_flag(done_flag),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // Advance to just after the next rising edge (sample/drive point).
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic capture(input int off, input int n);
    for (int i = 0; i < n; i++) begin
      cap_tx[off+i]   = data_tx;
      cap_done[off+i] = done_flag;
      tick();
    end
  endtask

  // Line level of bit k of an 8N1 frame carrying d.
  function automatic logic frame8n1(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    return 1'b1;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      wr_valid    = 1'($urandom);
      data_in     = 8'($urandom);
      tx_enable   = 1'($urandom);
      baud_div    = 16'($urandom);
      data_len    = 2'($urandom);
      parity_type = 2'($urandom);
      stop_bits   = 1'($urandom);
      tick();
    end
    n_chk++; if (data_tx !== 1'b1)     begin n_fail++; $display("FAIL reset_data_tx: got %b expected 1", data_tx); end
    n_chk++; if (active_flag !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", active_flag); end
    n_chk++; if (done_flag !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_flag); end
    n_chk++; if (fifo_count !== 5'd0)  begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    n_chk++; if (wr_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
    n_chk++; if (fifo_empty !== 1'b1)  begin n_fail++; $display("FAIL reset_empty: got %b expected 1", fifo_empty); end
    n_chk++; if (fifo_full !== 1'b0)   begin n_fail++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
    rst = 1'b1; wr_valid = 1'b0; tx_enable = 1'b0;
    tick(); tick();
  endtask

  // 0xA5, 8 data bits, even parity, 1 stop, 4 clocks per bit.
  task automatic test_frame_a5();
    logic [10:0] exp_line;
    int pulses;
    exp_line = 11'b10101001010;
    pulses = 0;
    baud_div = 16'd3; data_len = 2'b11; parity_type = 2'b10; stop_bits = 1'b0; tx_enable = 1'b1;
    data_in = 8'hA5; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    n_chk++; if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL a5_empty_c1: got %b expected 0", fifo_empty); end
    n_chk++; if (data_tx !== 1'b1)    begin n_fail++; $display("FAIL a5_line_c1: got %b expected 1", data_tx); end
    tick();
    n_chk++; if (data_tx !== 1'b0)    begin n_fail++; $display("FAIL a5_start_c2: got %b expected 0", data_tx); end
    capture(0, 44);
    for (int i = 0; i < 44; i++) begin
      n_chk++;
      if (cap_tx[i] !== exp_line[i/4]) begin n_fail++; $display("FAIL a5_line cycle %0d: got %b expected %b", i, cap_tx[i], exp_line[i/4]); end
      if (cap_done[i] === 1'b1) pulses++;
    end
    n_chk++; if (pulses != 1)             begin n_fail++; $display("FAIL a5_done_count: got %0d expected 1", pulses); end
    n_chk++; if (cap_done[43] !== 1'b1)   begin n_fail++; $display("FAIL a5_done_cycle44: got %b expected 1", cap_done[43]); end
    n_chk++; if (data_tx !== 1'b1)        begin n_fail++; $display("FAIL a5_idle_line: got %b expected 1", data_tx); end
    n_chk++; if (active_flag !== 1'b0)    begin n_fail++; $display("FAIL a5_idle_active: got %b expected 0", active_flag); end
    tick(); tick();
  endtask

  // 0xFF, 5 data bits, odd parity, 2 stops, 1 clock per bit.
  task automatic test_frame_ff();
    logic [8:0] exp_line;
    exp_line = 9'b110111110;
    baud_div = 16'd0; data_len = 2'b00; parity_type = 2'b01; stop_bits = 1'b1; tx_enable = 1'b1;
    data_in = 8'hFF; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    capture(0, 9);
    for (int i = 0; i < 9; i++) begin
      n_chk++;
      if (cap_tx[i] !== exp_line[i]) begin n_fail++; $display("FAIL ff_line cycle %0d: got %b expected %b", i, cap_tx[i], exp_line[i]); end
      n_chk++;
      if (cap_done[i] !== (i == 8)) begin n_fail++; $display("FAIL ff_done cycle %0d: got %b expected %b", i, cap_done[i], (i == 8)); end
    end
    n_chk++; if (active_flag !== 1'b0) begin n_fail++; $display("FAIL ff_idle_active: got %b expected 0", active_flag); end
    tick(); tick();
  endtask

  task automatic test_fifo_fill();
    logic [7:0] d [0:16];
    logic [7:0] got;
    int pulses;
    pulses = 0;
    for (int i = 0; i < 17; i++) d[i] = 8'((i * 37) ^ 8'h5C);
    baud_div = 16'd0; data_len = 2'b11; parity_type = 2'b00; stop_bits = 1'b0; tx_enable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      data_in = d[i]; wr_valid = 1'b1;
      tick();
    end
    n_chk++; if (fifo_full !== 1'b1)   begin n_fail++; $display("FAIL fill_full: got %b expected 1", fifo_full); end
    n_chk++; if (wr_ready !== 1'b0)    begin n_fail++; $display("FAIL fill_wr_ready: got %b expected 0", wr_ready); end
    n_chk++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL fill_count16: got %0d expected 16", fifo_count); end
    data_in = d[16];
    tick();
    wr_valid = 1'b0;
    n_chk++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL fill_drop17: got %0d expected 16", fifo_count); end
    n_chk++; if (data_tx !== 1'b1)     begin n_fail++; $display("FAIL fill_held: got %b expected 1", data_tx); end
    tx_enable = 1'b1;
    tick();
    capture(0, 160);
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 10; k++) begin
        n_chk++;
        if (cap_tx[j*10+k] !== frame8n1(d[j], k)) begin
          n_fail++; $display("FAIL fill_line frame %0d bit %0d: got %b expected %b", j, k, cap_tx[j*10+k], frame8n1(d[j], k));
        end
        if (cap_done[j*10+k] === 1'b1) pulses++;
      end
      for (int k = 0; k < 8; k++) got[k] = cap_tx[j*10+1+k];
      n_chk++; if (got !== d[j]) begin n_fail++; $display("FAIL fill_order frame %0d: got %h expected %h", j, got, d[j]); end
    end
    n_chk++; if (pulses != 16) begin n_fail++; $display("FAIL fill_done_count: got %0d expected 16", pulses); end
    for (int i = 0; i < 5; i++) tick();
    n_chk++; if (data_tx !== 1'b1 || active_flag !== 1'b0) begin
      n_fail++; $display("FAIL fill_no_17th: got line %b active %b expected 1 0", data_tx, active_flag);
    end
    n_chk++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty_end: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_reset_mid();
    int lows, pulses;
    lows = 0; pulses = 0;
    baud_div = 16'd3; data_len = 2'b11; parity_type = 2'b00; stop_bits = 1'b0; tx_enable = 1'b1;
    data_in = 8'h52; wr_valid = 1'b1;
    tick();
    data_in = 8'h11;
    tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    // cycle 17 of the frame: inside data bit 3 (0x52 bit 3 = 0)
    n_chk++; if (data_tx !== 1'b0)     begin n_fail++; $display("FAIL rmid_bit3: got %b expected 0", data_tx); end
    n_chk++; if (fifo_count !== 5'd1)  begin n_fail++; $display("FAIL rmid_pre_count: got %0d expected 1", fifo_count); end
    #2 rst = 1'b0;
    #1;
    n_chk++; if (data_tx !== 1'b1)     begin n_fail++; $display("FAIL rmid_line: got %b expected 1", data_tx); end
    n_chk++; if (fifo_count !== 5'd0)  begin n_fail++; $display("FAIL rmid_count: got %0d expected 0", fifo_count); end
    n_chk++; if (active_flag !== 1'b0) begin n_fail++; $display("FAIL rmid_active: got %b expected 0", active_flag); end
    n_chk++; if (done_flag !== 1'b0)   begin n_fail++; $display("FAIL rmid_done: got %b expected 0", done_flag); end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (data_tx !== 1'b1) lows++;
      if (done_flag !== 1'b0) pulses++;
      tick();
    end
    n_chk++; if (lows != 0)   begin n_fail++; $display("FAIL rmid_idle_after: got %0d non-high cycles expected 0", lows); end
    n_chk++; if (pulses != 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_midframe_change();
    logic [7:0] a, b;
    int lows;
    a = 8'h3C; b = 8'hC3; lows = 0;
    baud_div = 16'd3; data_len = 2'b11; parity_type = 2'b00; stop_bits = 1'b0; tx_enable = 1'b1;
    data_in = a; wr_valid = 1'b1;
    tick();
    data_in = b;
    tick();
    wr_valid = 1'b0;
    capture(0, 10);
    baud_div = 16'd7; tx_enable = 1'b0;
    capture(10, 30);
    for (int i = 0; i < 40; i++) begin
      n_chk++;
      if (cap_tx[i] !== frame8n1(a, i/4)) begin n_fail++; $display("FAIL mid_f1 cycle %0d: got %b expected %b", i, cap_tx[i], frame8n1(a, i/4)); end
    end
    n_chk++; if (cap_done[39] !== 1'b1) begin n_fail++; $display("FAIL mid_f1_done: got %b expected 1", cap_done[39]); end
    n_chk++; if (fifo_count !== 5'd1)   begin n_fail++; $display("FAIL mid_held_count: got %0d expected 1", fifo_count); end
    for (int i = 0; i < 50; i++) begin
      if (data_tx !== 1'b1 || active_flag !== 1'b0) lows++;
      tick();
    end
    n_chk++; if (lows != 0) begin n_fail++; $display("FAIL mid_no_start: got %0d busy cycles expected 0", lows); end
    tx_enable = 1'b1;
    tick();
    capture(0, 80);
    for (int i = 0; i < 80; i++) begin
      n_chk++;
      if (cap_tx[i] !== frame8n1(b, i/8)) begin n_fail++; $display("FAIL mid_f2 cycle %0d: got %b expected %b", i, cap_tx[i], frame8n1(b, i/8)); end
      n_chk++;
      if (cap_done[i] !== (i == 79)) begin n_fail++; $display("FAIL mid_f2_done cycle %0d: got %b expected %b", i, cap_done[i], (i == 79)); end
    end
    n_chk++; if (active_flag !== 1'b0 || fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL mid_end: got active %b empty %b expected 0 1", active_flag, fifo_empty);
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_frame_ff();
    test_fifo_fill();
    test_reset_mid();
    test_midframe_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Next-generation UART transmitter with a configurable frame format and a programmable baud divisor. A write-side FIFO buffers bytes so frames go out back-to-back without software pacing. It sits between the system bus/controller logic and the serial data_tx pin, and pairs with the existing Rx unit using the same parity and line conventions. The baud generator, parity unit and shift register are merged into one block, and every frame option is selectable at run time.

Parameters:
FIFO_DEPTH, 16, number of 8-bit FIFO entries; power of 2, minimum 2
DIV_WIDTH, 16, width of the baud_div port

Ports:
clock  input  1  system clock
rst  input  1  asynchronous active-low reset
wr_valid  input  1  a byte is offered on data_in
data_in  input  8  byte to transmit, sent LSB first
wr_ready  output  1  FIFO can accept a byte; equals !fifo_full
tx_enable  input  1  1 allows new frames to start; 0 holds the FIFO contents
baud_div  input  DIV_WIDTH  bit period is baud_div+1 clock cycles
data_len  input  2  data bits per frame: 00=5, 01=6, 10=7, 11=8
parity_type  input  2  00=none, 01=odd, 10=even, 11=none
stop_bits  input  1  0 = one stop bit, 1 = two stop bits
data_tx  output  1  serial line; idles high
active_flag  output  1  high from the first start-bit cycle to the last stop-bit cycle
done_flag  output  1  one-cycle pulse when a frame's last stop bit completes
fifo_empty  output  1  FIFO holds no bytes
fifo_full  output  1  FIFO holds FIFO_DEPTH bytes
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes in the FIFO

Behaviour:
- Reset (asynchronous, while rst=0):
  - data_tx=1, active_flag=0, done_flag=0.
  - FIFO is emptied: fifo_empty=1, fifo_full=0, fifo_count=0, wr_ready=1.
  - FSM goes to IDLE and all counters are cleared.
  - Reset applied mid-frame aborts the frame immediately; data_tx returns high with no further output.
- FIFO write:
  - A byte is pushed on the rising edge when wr_valid && wr_ready.
  - A write while full is ignored; the byte is dropped and the count is unchanged.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - There is no bypass path: a byte written into an empty FIFO is popped no earlier than the next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - data_tx=1.
  - If tx_enable && !fifo_empty, pop the head byte into the shift register.
  - In the same cycle, latch baud_div, data_len, parity_type and stop_bits, and compute parity over the active data bits only.
  - Go to START on the next cycle.
  - Latency: a write at cycle 0 makes fifo_empty=0 at cycle 1 and the pop happen at cycle 1; data_tx goes low at cycle 2.
- Bit timing:
  - A divisor counter runs from 0 to the latched baud_div; each bit lasts baud_div+1 cycles.
  - baud_div=0 gives one cycle per bit.
- START: data_tx=0 for one bit period, then DATA.
- DATA:
  - Sends bit[i] for i=0 to len-1, where len = 5 + data_len.
  - Upper data_in bits beyond len are ignored.
  - Then PARITY if parity is enabled, otherwise STOP.
- PARITY:
  - Even: the bit equals the XOR of the active data bits.
  - Odd: the bit equals the inverse of that XOR.
  - One bit period, then STOP.
- STOP:
  - data_tx=1 for one bit period, or two if the latched stop_bits=1.
  - At the final cycle of the last stop period, done_flag=1 for exactly that cycle.
  - If tx_enable && !fifo_empty in that cycle: pop and latch as in IDLE, then go straight to START, so there is no idle gap between frames.
  - Otherwise go to IDLE.
- active_flag is 1 in START, DATA, PARITY and STOP; it is 0 in IDLE.
- Configuration inputs changing mid-frame do not affect the frame in flight; new values apply from the next pop.
- tx_enable dropping mid-frame lets the current frame finish; no new frame starts until tx_enable returns to 1.
- Frame length in cycles: (1 + len + P + S) × (baud_div+1), where P is 1 when parity is enabled (else 0) and S is 1 or 2.

Test Plan:
- Reset: hold rst=0 with random inputs -> data_tx=1, active_flag=0, done_flag=0, fifo_count=0, wr_ready=1, fifo_empty=1.
- baud_div=3, data_len=11, parity even, 1 stop, write 0xA5:
  - Line is 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles, 44 cycles total.
  - data_tx goes low 2 cycles after the write.
  - done_flag pulses once, at cycle 44 of the frame.
- baud_div=0, data_len=00, parity odd, 2 stops, write 0xFF -> line is 0,1,1,1,1,1,0,1,1, one cycle per bit, 9 cycles total.
- FIFO fill:
  - With tx_enable=0, write 17 bytes -> after 16 writes fifo_full=1, wr_ready=0, fifo_count=16; the 17th byte is dropped.
  - Then set tx_enable=1 -> 16 frames go out back-to-back with no high gap beyond the stop bits; 16 done_flag pulses; the bytes arrive in write order.
- Reset mid-frame: assert rst=0 during data bit 3 -> data_tx=1 in the same cycle, fifo_count=0, no done_flag pulse; after release the line stays idle.
- Mid-frame changes: change baud_div from 3 to 7 and set tx_enable=0 during frame 1 of 2 queued bytes:
  - Frame 1 completes at 4 cycles per bit.
  - Frame 2 does not start while tx_enable=0.
  - After re-enable, frame 2 runs at 8 cycles per bit.
